// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch/execute bus between the pipeline and the branch target buffer
//
// Purpose: bundles the IF-stage lookup path, the EX-stage resolve/update path
// and the mispredict redirect path into one bus.
//
// Signals (ADDR_W = PC/target width, must match the attached buffer):
//   lookup_pc      IF-stage PC to predict for
//   pred_hit       valid entry with matching tag for lookup_pc
//   pred_taken     predict taken
//   pred_target    stored target on a hit, else 0
//   update_en      EX resolved a control-flow instruction this cycle
//   update_pc      PC of the resolved instruction
//   update_taken   actual outcome
//   update_target  actual taken target
//   ex_pred_taken  prediction carried down the pipe with the instruction
//   ex_pred_target predicted target carried down the pipe
//   flush_all      invalidate every entry
//   mispredict     EX must redirect fetch and flush IF/ID and ID/EX
//   correct_pc     redirect PC when mispredict
//
// Modports: master = pipeline side, slave = branch target buffer side.

interface branch_target_buffer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    logic              update_en;
    logic [ADDR_W-1:0] update_pc;
    logic              update_taken;
    logic [ADDR_W-1:0] update_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              flush_all;

    logic              mispredict;
    logic [ADDR_W-1:0] correct_pc;

    modport master (
        output lookup_pc,
        output update_en,
        output update_pc,
        output update_taken,
        output update_target,
        output ex_pred_taken,
        output ex_pred_target,
        output flush_all,
        input  pred_hit,
        input  pred_taken,
        input  pred_target,
        input  mispredict,
        input  correct_pc
    );

    modport slave (
        input  lookup_pc,
        input  update_en,
        input  update_pc,
        input  update_taken,
        input  update_target,
        input  ex_pred_taken,
        input  ex_pred_target,
        input  flush_all,
        output pred_hit,
        output pred_taken,
        output pred_target,
        output mispredict,
        output correct_pc
    );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with saturating-counter prediction
//
// Purpose: IF looks up lookup_pc combinationally to choose the next PC; EX
// writes resolved outcomes back at the clock edge and gets a combinational
// mispredict flag plus the corrected fetch PC.
//
// Parameters:
//   ENTRIES  number of direct-mapped entries (power of 2, >= 2)
//   CTR_W    saturating-counter width (>= 1)
//   ADDR_W   PC/target width; PCs are word-aligned, bits [1:0] ignored
//
// Ports:
//   CLK      clock
//   nRST     asynchronous active-low reset
//   bus      branch_target_buffer_if.slave (lookup, update, redirect)
//
// Optional feature (macro BTB_STATS_EN):
//   stat_updates      32-bit saturating count of update_en cycles
//   stat_mispredicts  32-bit saturating count of mispredict cycles
//   Both clear on nRST only; flush_all leaves them alone.

module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int ADDR_W  = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    branch_target_buffer_if.slave bus
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]           stat_updates,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Weakly-not-taken sits just below the MSB threshold, weakly-taken just
    // at it. With CTR_W=1 these collapse to 0 and 1.
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup (IF): purely combinational against the registered state, so a
    // same-cycle update to the same index is not visible until next cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = bus.lookup_pc[IDX_W+1:2];
    assign lk_tag = bus.lookup_pc[ADDR_W-1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign bus.pred_hit    = lk_hit;
    assign bus.pred_taken  = lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign bus.pred_target = lk_hit ? target_q[lk_idx] : '0;

    // Byte-offset bits of the fetch PC carry no information here.
    logic unused_lookup_lsbs;
    assign unused_lookup_lsbs = ^bus.lookup_pc[1:0];

    // ------------------------------------------------------------------
    // Update (EX): decode the resolved PC and compute the entry's next
    // counter value.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [CTR_W-1:0] up_ctr;
    logic [CTR_W-1:0] up_ctr_next;

    assign up_idx = bus.update_pc[IDX_W+1:2];
    assign up_tag = bus.update_pc[ADDR_W-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr = ctr_q[up_idx];

    // Saturating step: never wraps past either end of the range.
    always_comb begin
        up_ctr_next = up_ctr;
        if (bus.update_taken) begin
            if (up_ctr != CTR_MAX) begin
                up_ctr_next = up_ctr + CTR_W'(1);
            end
        end else begin
            if (up_ctr != CTR_MIN) begin
                up_ctr_next = up_ctr - CTR_W'(1);
            end
        end
    end

    // flush_all wins over a same-cycle update, which is simply dropped.
    // A tag miss on a not-taken branch leaves the entry untouched so a
    // not-taken alias cannot evict a useful taken entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (bus.flush_all) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else if (bus.update_en) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_next;
                if (bus.update_taken) begin
                    target_q[up_idx] <= bus.update_target;
                end
            end else if (bus.update_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bus.update_target;
                ctr_q[up_idx]    <= CTR_WT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mispredict detection and redirect. A not-taken branch that was
    // predicted not-taken is fine regardless of the carried target.
    // ------------------------------------------------------------------
    logic mispredict_c;

    assign mispredict_c = bus.update_en &&
                          ((bus.ex_pred_taken != bus.update_taken) ||
                           (bus.update_taken && (bus.ex_pred_target != bus.update_target)));

    assign bus.mispredict = mispredict_c;
    assign bus.correct_pc = bus.update_taken ? bus.update_target
                                             : bus.update_pc + ADDR_W'(4);

`ifdef BTB_STATS_EN
    // ------------------------------------------------------------------
    // Event counters: registered, so each event shows up one cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (bus.update_en && (stat_updates != 32'hFFFF_FFFF)) begin
                stat_updates <= stat_updates + 32'd1;
            end
            if (mispredict_c && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer against a behavioural model

module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int ADDR_W  = 32;
    localparam int IDX_W   = $clog2(ENTRIES);

    localparam int M_WNT = (1 << (CTR_W - 1)) - 1;
    localparam int M_WT  = 1 << (CTR_W - 1);
    localparam int M_MAX = (1 << CTR_W) - 1;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    branch_target_buffer_if #(.ADDR_W(ADDR_W)) bus();

`ifdef BTB_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    branch_target_buffer #(
        .ENTRIES (ENTRIES),
        .CTR_W   (CTR_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .bus              (bus)
`ifdef BTB_STATS_EN
        ,
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    int tests;
    int fails;

    // ------------------------------------------------------------------
    // Behavioural model: one record per index, rules applied in plain code.
    // ------------------------------------------------------------------
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_su;
    logic [31:0] m_sm;

    function automatic int m_idx(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] m_tagof(logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_taken(logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= M_WT);
    endfunction

    function automatic logic [31:0] m_tgt(logic [31:0] pc);
        return m_hit(pc) ? m_target[m_idx(pc)] : 32'h0;
    endfunction

    function automatic bit m_mispredict();
        if (!bus.update_en) return 1'b0;
        if (bus.ex_pred_taken != bus.update_taken) return 1'b1;
        return bus.update_taken && (bus.ex_pred_target != bus.update_target);
    endfunction

    function automatic logic [31:0] m_correct();
        return bus.update_taken ? bus.update_target : bus.update_pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k]  = 1'b0;
            m_tag[k]    = 32'h0;
            m_target[k] = 32'h0;
            m_ctr[k]    = M_WNT;
        end
        m_su = 32'h0;
        m_sm = 32'h0;
    endtask

    task automatic idle();
        bus.update_en      = 1'b0;
        bus.update_pc      = 32'h0;
        bus.update_taken   = 1'b0;
        bus.update_target  = 32'h0;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = 32'h0;
        bus.flush_all      = 1'b0;
    endtask

    task automatic set_update(logic [31:0] pc, bit taken, logic [31:0] tgt,
                              bit ep_taken, logic [31:0] ep_tgt);
        bus.update_en      = 1'b1;
        bus.update_pc      = pc;
        bus.update_taken   = taken;
        bus.update_target  = tgt;
        bus.ex_pred_taken  = ep_taken;
        bus.ex_pred_target = ep_tgt;
    endtask

    // Advances one clock from mid-low phase: samples the held inputs, lets
    // the posedge happen, applies the same event to the model, and returns
    // at the following negedge.
    task automatic tick();
        bit          ue, tk, fl, mis;
        logic [31:0] pc, tgt, tg;
        int          i;
        ue  = bus.update_en;
        tk  = bus.update_taken;
        fl  = bus.flush_all;
        pc  = bus.update_pc;
        tgt = bus.update_target;
        mis = m_mispredict();
        @(posedge CLK);
        if (ue && m_su != 32'hFFFF_FFFF) m_su = m_su + 32'd1;
        if (mis && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 32'd1;
        if (fl) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = M_WNT;
            end
        end else if (ue) begin
            i  = m_idx(pc);
            tg = m_tagof(pc);
            if (m_valid[i] && m_tag[i] == tg) begin
                if (tk) begin
                    m_ctr[i]    = (m_ctr[i] >= M_MAX) ? M_MAX : m_ctr[i] + 1;
                    m_target[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (tk) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tg;
                m_target[i] = tgt;
                m_ctr[i]    = M_WT;
            end
        end
        @(negedge CLK);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle();
        bus.lookup_pc = 32'h40;
        #1;
        tests++; if (bus.pred_hit !== 1'b0) begin fails++; $display("FAIL reset_hit: got %0b want 0", bus.pred_hit); end
        tests++; if (bus.pred_taken !== 1'b0) begin fails++; $display("FAIL reset_taken: got %0b want 0", bus.pred_taken); end
        tests++; if (bus.pred_target !== 32'h0) begin fails++; $display("FAIL reset_target: got %h want 0", bus.pred_target); end
        tests++; if (bus.mispredict !== 1'b0) begin fails++; $display("FAIL reset_mispredict: got %0b want 0", bus.mispredict); end
`ifdef BTB_STATS_EN
        tests++; if (stat_updates !== 32'h0) begin fails++; $display("FAIL reset_stat_updates: got %0d want 0", stat_updates); end
        tests++; if (stat_mispredicts !== 32'h0) begin fails++; $display("FAIL reset_stat_mispredicts: got %0d want 0", stat_mispredicts); end
`endif
        @(negedge CLK);
    endtask

    task automatic test_alloc_counter();
        set_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        idle();
        bus.lookup_pc = 32'h40;
        #1;
        tests++; if (bus.pred_hit !== 1'b1) begin fails++; $display("FAIL alloc_hit: got %0b want 1", bus.pred_hit); end
        tests++; if (bus.pred_taken !== 1'b1) begin fails++; $display("FAIL alloc_taken: got %0b want 1", bus.pred_taken); end
        tests++; if (bus.pred_target !== 32'h100) begin fails++; $display("FAIL alloc_target: got %h want 100", bus.pred_target); end
        set_update(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        tick();
        idle();
        #1;
        tests++; if (bus.pred_hit !== 1'b1) begin fails++; $display("FAIL nt_hit: got %0b want 1", bus.pred_hit); end
        tests++; if (bus.pred_taken !== 1'b0) begin fails++; $display("FAIL nt_taken: got %0b want 0", bus.pred_taken); end
        tests++; if (bus.pred_target !== 32'h100) begin fails++; $display("FAIL nt_target_kept: got %h want 100", bus.pred_target); end
    endtask

    task automatic test_saturation_replace();
        for (int n = 0; n < 3; n++) begin
            set_update(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            tick();
        end
        idle();
        bus.lookup_pc = 32'h40;
        #1;
        tests++; if (bus.pred_taken !== 1'b1) begin fails++; $display("FAIL sat_top_taken: got %0b want 1", bus.pred_taken); end
        set_update(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        tick();
        idle();
        #1;
        tests++; if (bus.pred_taken !== 1'b1) begin fails++; $display("FAIL sat_dec_taken: got %0b want 1", bus.pred_taken); end
        set_update(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
        tick();
        idle();
        bus.lookup_pc = 32'h40;
        #1;
        tests++; if (bus.pred_hit !== 1'b0) begin fails++; $display("FAIL replace_old_miss: got %0b want 0", bus.pred_hit); end
        bus.lookup_pc = 32'h80;
        #1;
        tests++; if (bus.pred_hit !== 1'b1) begin fails++; $display("FAIL replace_new_hit: got %0b want 1", bus.pred_hit); end
        tests++; if (bus.pred_target !== 32'h200) begin fails++; $display("FAIL replace_new_target: got %h want 200", bus.pred_target); end
        tests++; if (bus.pred_taken !== 1'b1) begin fails++; $display("FAIL replace_new_taken: got %0b want 1", bus.pred_taken); end
    endtask

    task automatic test_mispredict();
        logic [31:0] pcs  [5] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'hFFFF_FFFC};
        bit          tks  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] tgts [5] = '{32'h100, 32'h0, 32'h300, 32'h300, 32'h500};
        bit          eps  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ept  [5] = '{32'h0, 32'h100, 32'h300, 32'h304, 32'h700};
        bit          wmis [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] wpc  [5] = '{32'h100, 32'h44, 32'h300, 32'h300, 32'h0};
        for (int n = 0; n < 5; n++) begin
            set_update(pcs[n], tks[n], tgts[n], eps[n], ept[n]);
            #1;
            tests++; if (bus.mispredict !== wmis[n]) begin fails++; $display("FAIL mispredict_%0d: got %0b want %0b", n, bus.mispredict, wmis[n]); end
            tests++; if (bus.correct_pc !== wpc[n]) begin fails++; $display("FAIL correct_pc_%0d: got %h want %h", n, bus.correct_pc, wpc[n]); end
            idle();
            @(negedge CLK);
        end
    endtask

    task automatic test_flush_and_same_cycle();
        set_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        bus.flush_all = 1'b1;
        tick();
        idle();
        bus.lookup_pc = 32'h40;
        #1;
        tests++; if (bus.pred_hit !== 1'b0) begin fails++; $display("FAIL flush_drop_update: got %0b want 0", bus.pred_hit); end
        bus.lookup_pc = 32'h80;
        #1;
        tests++; if (bus.pred_hit !== 1'b0) begin fails++; $display("FAIL flush_clears: got %0b want 0", bus.pred_hit); end
        bus.lookup_pc = 32'h40;
        set_update(32'h40, 1'b1, 32'h140, 1'b0, 32'h0);
        #1;
        tests++; if (bus.pred_hit !== 1'b0) begin fails++; $display("FAIL same_cycle_old: got %0b want 0", bus.pred_hit); end
        tick();
        idle();
        #1;
        tests++; if (bus.pred_hit !== 1'b1) begin fails++; $display("FAIL same_cycle_new_hit: got %0b want 1", bus.pred_hit); end
        tests++; if (bus.pred_target !== 32'h140) begin fails++; $display("FAIL same_cycle_new_target: got %h want 140", bus.pred_target); end
        @(negedge CLK);
    endtask

    task automatic test_async_reset();
        set_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        tick();
        idle();
        bus.lookup_pc = 32'h40;
        #1;
        tests++; if (bus.pred_hit !== 1'b1) begin fails++; $display("FAIL areset_pre_hit: got %0b want 1", bus.pred_hit); end
        #1;
        nRST = 1'b0;
        model_reset();
        #1;
        tests++; if (bus.pred_hit !== 1'b0) begin fails++; $display("FAIL areset_hit: got %0b want 0", bus.pred_hit); end
        tests++; if (bus.pred_target !== 32'h0) begin fails++; $display("FAIL areset_target: got %h want 0", bus.pred_target); end
`ifdef BTB_STATS_EN
        tests++; if (stat_updates !== 32'h0) begin fails++; $display("FAIL areset_stat_updates: got %0d want 0", stat_updates); end
        tests++; if (stat_mispredicts !== 32'h0) begin fails++; $display("FAIL areset_stat_mispredicts: got %0d want 0", stat_mispredicts); end
`endif
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        tests++; if (bus.pred_hit !== 1'b0) begin fails++; $display("FAIL areset_release_hit: got %0b want 0", bus.pred_hit); end
        @(negedge CLK);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] hi;
        hi = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 : 32'h0;
        return hi | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                  | 32'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        logic [31:0] upc;
        for (int c = 0; c < 800; c++) begin
            bus.lookup_pc = rand_pc();
            upc = rand_pc();
            bus.update_en     = ($urandom_range(0, 99) < 60);
            bus.update_pc     = upc;
            bus.update_taken  = 1'($urandom_range(0, 1));
            bus.update_target = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 1) == 1) begin
                bus.ex_pred_taken  = m_taken(upc);
                bus.ex_pred_target = m_tgt(upc);
            end else begin
                bus.ex_pred_taken  = 1'($urandom_range(0, 1));
                bus.ex_pred_target = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
            end
            bus.flush_all = ($urandom_range(0, 99) < 2);
            #1;
            tests++; if (bus.pred_hit !== m_hit(bus.lookup_pc)) begin fails++; $display("FAIL rnd_hit c=%0d pc=%h: got %0b want %0b", c, bus.lookup_pc, bus.pred_hit, m_hit(bus.lookup_pc)); end
            tests++; if (bus.pred_taken !== m_taken(bus.lookup_pc)) begin fails++; $display("FAIL rnd_taken c=%0d pc=%h: got %0b want %0b", c, bus.lookup_pc, bus.pred_taken, m_taken(bus.lookup_pc)); end
            tests++; if (bus.pred_target !== m_tgt(bus.lookup_pc)) begin fails++; $display("FAIL rnd_target c=%0d pc=%h: got %h want %h", c, bus.lookup_pc, bus.pred_target, m_tgt(bus.lookup_pc)); end
            tests++; if (bus.mispredict !== m_mispredict()) begin fails++; $display("FAIL rnd_mispredict c=%0d: got %0b want %0b", c, bus.mispredict, m_mispredict()); end
            tests++; if (bus.correct_pc !== m_correct()) begin fails++; $display("FAIL rnd_correct_pc c=%0d: got %h want %h", c, bus.correct_pc, m_correct()); end
            tick();
`ifdef BTB_STATS_EN
            tests++; if (stat_updates !== m_su) begin fails++; $display("FAIL rnd_stat_updates c=%0d: got %0d want %0d", c, stat_updates, m_su); end
            tests++; if (stat_mispredicts !== m_sm) begin fails++; $display("FAIL rnd_stat_mispredicts c=%0d: got %0d want %0d", c, stat_mispredicts, m_sm); end
`endif
        end
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        nRST  = 1'b0;
        idle();
        bus.lookup_pc = 32'h0;
        model_reset();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        test_reset();
        test_alloc_counter();
        test_saturation_replace();
        test_mispredict();
        test_flush_and_same_cycle();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Parametrised branch predictor and target buffer for the 5-stage pipeline. IF looks it up combinationally to pick the next PC. EX resolves branches and jumps and writes the outcome back into it. It also flags mispredicts and supplies the corrected PC, so fetch no longer waits for EX on every branch.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of 2, >= 2; IDX_W = log2(ENTRIES)
CTR_W, 2, saturating-counter width, >= 1
ADDR_W, 32, PC/target width; PCs word-aligned, bits [1:0] ignored

Ports:
CLK  input  1  clock
nRST  input  1  reset, asynchronous, active-low
lookup_pc  input  ADDR_W  IF-stage PC
pred_hit  output  1  valid entry with matching tag for lookup_pc
pred_taken  output  1  predict taken (pred_hit && counter MSB == 1)
pred_target  output  ADDR_W  stored target when pred_hit, else 0
update_en  input  1  EX resolved a control-flow instruction this cycle
update_pc  input  ADDR_W  PC of the resolved instruction
update_taken  input  1  actual outcome
update_target  input  ADDR_W  actual taken target
ex_pred_taken  input  1  prediction carried down the pipe with the instruction
ex_pred_target  input  ADDR_W  predicted target carried down the pipe
flush_all  input  1  invalidate every entry
mispredict  output  1  EX must redirect fetch and flush IF/ID and ID/EX
correct_pc  output  ADDR_W  redirect PC when mispredict

Behaviour:
- Clocking and reset: CLK is the clock. nRST is an asynchronous, active-low reset.
- Index and tag: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag, target and counter.
- Reset state: nRST low clears all valid bits immediately, even mid-operation. Counters go to weakly-not-taken, 2^(CTR_W-1)-1 (CTR_W=1 gives 0). Targets and tags go to 0.
- Outputs after reset: pred_hit=0, pred_taken=0, pred_target=0. mispredict=0 unless update_en is asserted.
- Lookup: purely combinational, zero latency.
- Update: registered and applied at the posedge with update_en=1.
  - Tag hit: the counter saturating-increments on taken and saturating-decrements on not-taken. The target is overwritten only when taken.
  - Tag miss, taken: allocate or replace. valid=1, tag and target written, counter = weakly-taken 2^(CTR_W-1).
  - Tag miss, not-taken: no change to the entry.
- Saturation: the counter never wraps; it stays at 0 or 2^CTR_W-1.
- Lookup and update in the same cycle to the same index: the lookup returns the pre-update state. There is no bypass; the new state is visible the next cycle.
- flush_all: registered. Clears all valids and resets counters to weakly-not-taken. It takes priority over an update in the same cycle; that update is dropped.
- mispredict is combinational. It asserts when update_en && ((ex_pred_taken != update_taken) || (update_taken && ex_pred_target != update_target)).
- correct_pc = update_taken ? update_target : update_pc + 4, modulo 2^ADDR_W. Its value is don't-care when mispredict=0, but the driven value is deterministic.
- Stalls: the datapath holds update_en low during stalls. The block has no internal stall state.

Optional Feature:
Macro BTB_STATS_EN.
- Defined: adds output ports stat_updates (32 bits, count of update_en cycles) and stat_mispredicts (32 bits, count of mispredict cycles).
  - Both reset to 0 on nRST and saturate at 32'hFFFF_FFFF.
  - flush_all does not clear them.
  - Both increment in the cycle after the qualifying event.
- Undefined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
(Values use ENTRIES=16, CTR_W=2, ADDR_W=32. PC 0x40 has index 0, tag 1; PC 0x80 has index 0, tag 2.)
1. Reset, then lookup 0x40 -> pred_hit=0, pred_taken=0, pred_target=0x0.
2. Update 0x40 taken with target 0x100; next cycle lookup 0x40 -> hit=1, taken=1 (ctr=2), target 0x100. Then update not-taken -> hit=1, taken=0 (ctr=1).
3. Three taken updates on 0x40 (ctr=3), then one not-taken -> ctr=2 and pred_taken still 1. Then update 0x80 taken with target 0x200 -> lookup 0x40 misses, lookup 0x80 hits with target 0x200.
4. update_en with ex_pred_taken=0, update_taken=1, target 0x100 -> mispredict=1, correct_pc=0x100.
   update_pc=0x40, ex_pred_taken=1, update_taken=0 -> mispredict=1, correct_pc=0x44.
   Matching prediction and target -> mispredict=0.
5. flush_all and a taken update to 0x40 in the same cycle -> next cycle lookup 0x40 misses. Lookup and update to the same index in one cycle -> old value seen that cycle, new value the next.
6. Assert nRST low between clock edges with valid entries present -> pred_hit drops immediately. With BTB_STATS_EN defined, both stat counters read 0 after reset.
